rx_slot_arbiter: RTL
====================

Name: rx_slot_arbiter

Overview:
- Collects one decimated IQ sample from each active DDC receiver into a per-receiver holding register.
- Once every active receiver holds a sample, emits one "round": the samples in order rx0..rx(n-1) on a single valid/ready stream feeding the Ethernet packet formatter.
- Sits between the NR receiver chains and the TX-to-host sample FIFO inside the core.
- Tracks per-receiver overrun when a receiver produces a sample before its previous one was sent.

Parameters:
- NR, 6, number of receiver channels; legal range 1..7.
- DW, 24, width of each I and Q sample word.

Ports:
- clk  in  1  system clock; all logic is in this single domain.
- rst  in  1  reset, synchronous, active-high.
- active_nrx  in  3  requested number of active receivers; 0 treated as 1; values above NR clamped to NR.
- rx_valid  in  NR  per-receiver one-cycle sample strobe.
- rx_i  in  NR*DW  receiver I samples; receiver k occupies bits [k*DW +: DW].
- rx_q  in  NR*DW  receiver Q samples; same packing as rx_i.
- out_tdata  out  2*DW  {I,Q} of the sample being offered; I in the upper half.
- out_tvalid  out  1  sample offered.
- out_tready  in  1  downstream accepts.
- out_tfirst  out  1  offered sample is from rx0 (first of round).
- out_tlast  out  1  offered sample is from rx(n-1) (last of round).
- overrun  out  NR  sticky per-receiver overrun flags.
- overrun_clr  in  1  clears all overrun flags.
- busy  out  1  high while state is SEND.

Behaviour:
- Reset values:
  - state=IDLE, idx=0, full=0, buffers=0, nrx_lat=1.
  - out_tvalid=0, out_tfirst=0, out_tlast=0, out_tdata=0, overrun=0, busy=0.
- Outputs are driven only from registers; there is no combinational path from rx_* to out_*.
- Capture, for each k < nrx_lat:
  - rx_valid[k] with full[k]=0: buffer k <= {rx_i,rx_q} slice, full[k] <= 1.
  - rx_valid[k] with full[k]=1, no handshake on k this cycle: sample is dropped, buffer is unchanged, overrun[k] <= 1.
  - rx_valid[k] in the same cycle as the handshake of buffer k: new sample captured, full[k] stays 1, no overrun.
- Receivers with k >= nrx_lat: rx_valid is ignored, and full[k] and overrun[k] are held at 0.
- State IDLE:
  - Every cycle, nrx_lat <= clamp(active_nrx), and full bits at or above the new count are cleared.
  - When full[nrx_lat-1:0] is all ones (registered value) -> SEND next cycle with idx=0.
  - out_tvalid rises in the cycle after the last full bit is set.
- State SEND:
  - out_tvalid=1, out_tdata=buffer[idx], out_tfirst=(idx==0), out_tlast=(idx==nrx_lat-1).
  - On out_tvalid&&out_tready: full[idx] <= 0.
    - If idx<nrx_lat-1: idx++.
    - Otherwise -> IDLE and idx <= 0.
  - out_tvalid deasserts in the cycle after the last handshake.
  - out_tdata is held stable while out_tvalid=1 and out_tready=0.
  - nrx_lat is frozen; active_nrx changes take effect only in IDLE.
- At least one IDLE cycle separates rounds, even if all buffers refilled during SEND.
- overrun_clr clears all flags; a new overrun set in the same cycle wins.
- rst mid-round: returns immediately to reset values; any partial round is discarded.

Test Plan:
- active_nrx=3; strobe rx0,rx1,rx2 in cycles 1,4,6; out_tready=1 -> out_tvalid rises cycle 8. Beats are rx0 (tfirst=1), rx1, rx2 (tlast=1) in cycles 8-10; back to IDLE at cycle 11.
- active_nrx=6; all rx_valid together; out_tready toggles 1/0 -> 6 beats in order, tdata stable during stalls, exactly one tfirst and one tlast.
- active_nrx=2; strobe rx0 twice before rx1 -> overrun=6'b000001, first rx0 sample emitted. overrun_clr then clears it. overrun_clr coincident with a new rx0 overrun -> flag remains 1.
- During SEND of a 2-rx round, strobe rx0 in the same cycle as its handshake -> no overrun, and the new sample appears in the next round.
- Change active_nrx 6->2 mid-SEND -> current round completes with 6 beats, the next round has 2 beats. active_nrx=0 -> 1-beat rounds with tfirst=tlast=1. active_nrx=7 with NR=6 -> 6-beat rounds.
- Assert rst during beat 3 of a 6-beat round -> next cycle out_tvalid=0, full=0, overrun=0, nrx_lat=1.

Source files
------------

// File: rtl/rx_slot_arbiter.sv
// Gathers one IQ sample per active receiver, then streams the round rx0..rx(n-1)
// on a registered valid/ready interface with per-receiver sticky overrun flags.
module rx_slot_arbiter #(
  parameter int unsigned NR = 6,
  parameter int unsigned DW = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        active_nrx,
  input  logic [NR-1:0]     rx_valid,
  input  logic [NR*DW-1:0]  rx_i,
  input  logic [NR*DW-1:0]  rx_q,
  output logic [2*DW-1:0]   out_tdata,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic              out_tfirst,
  output logic              out_tlast,
  output logic [NR-1:0]     overrun,
  input  logic              overrun_clr,
  output logic              busy
);

  localparam int unsigned CW = 3;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic [CW-1:0]      idx;
  logic [CW-1:0]      idx_next;
  logic [CW-1:0]      nrx_lat;
  logic [CW-1:0]      nrx_next;
  logic [CW-1:0]      nrx_req;
  logic [NR-1:0]      full;
  logic [NR-1:0]      full_next;
  logic [NR-1:0]      ovr_next;
  logic [NR-1:0]      lat_mask;
  logic [NR-1:0]      keep_mask;
  logic [NR-1:0]      hs_mask;
  logic [NR-1:0]      accept;
  logic [NR-1:0]      ovr_set;
  logic [2*DW-1:0]    buffer [NR];
  logic               hs;
  logic               all_full;
  logic               last_beat;

  // Requested receiver count: 0 means 1, anything above NR means NR
  always_comb begin
    nrx_req = active_nrx;
    if (active_nrx == CW'(0)) begin
      nrx_req = CW'(1);
    end else if (active_nrx > CW'(NR)) begin
      nrx_req = CW'(NR);
    end
  end

  assign hs        = out_tvalid && out_tready;
  assign last_beat = (idx == nrx_lat - CW'(1));

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      lat_mask[k] = (CW'(k) < nrx_lat);
    end
  end

  assign all_full = &(full | ~lat_mask);

  // Next-state logic; the count only tracks active_nrx while staying in IDLE
  always_comb begin
    state_next = state;
    idx_next   = idx;
    nrx_next   = nrx_lat;
    case (state)
      S_IDLE: begin
        if (all_full) begin
          state_next = S_SEND;
          idx_next   = CW'(0);
        end else begin
          nrx_next = nrx_req;
        end
      end
      S_SEND: begin
        if (hs) begin
          if (last_beat) begin
            state_next = S_IDLE;
            idx_next   = CW'(0);
          end else begin
            idx_next = idx + CW'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = CW'(0);
      end
    endcase
  end

  // Capture/overrun per receiver; a handshake on slot k frees it for a same-cycle sample
  always_comb begin
    for (int k = 0; k < NR; k++) begin
      hs_mask[k]   = hs && (idx == CW'(k));
      accept[k]    = rx_valid[k] && lat_mask[k] && (!full[k] || hs_mask[k]);
      ovr_set[k]   = rx_valid[k] && lat_mask[k] && full[k] && !hs_mask[k];
      keep_mask[k] = (CW'(k) < nrx_next);
    end
    full_next = ((full & ~hs_mask) | accept) & keep_mask;
    ovr_next  = ((overrun & ~{NR{overrun_clr}}) | ovr_set) & keep_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= CW'(0);
      nrx_lat    <= CW'(1);
      full       <= '0;
      overrun    <= '0;
      out_tvalid <= 1'b0;
      out_tfirst <= 1'b0;
      out_tlast  <= 1'b0;
      out_tdata  <= '0;
      busy       <= 1'b0;
      for (int k = 0; k < NR; k++) begin
        buffer[k] <= '0;
      end
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      nrx_lat    <= nrx_next;
      full       <= full_next;
      overrun    <= ovr_next;
      out_tvalid <= (state_next == S_SEND);
      busy       <= (state_next == S_SEND);
      out_tfirst <= (state_next == S_SEND) && (idx_next == CW'(0));
      out_tlast  <= (state_next == S_SEND) && (idx_next == nrx_next - CW'(1));
      // The offered slot is full and not handshaken, so its buffer cannot change under it
      out_tdata  <= (state_next == S_SEND) ? buffer[idx_next] : '0;
      for (int k = 0; k < NR; k++) begin
        if (accept[k]) begin
          buffer[k] <= {rx_i[k*DW +: DW], rx_q[k*DW +: DW]};
        end
      end
    end
  end

endmodule
